// File: rtl/tile_pkg.sv
// Shared state encoding, key-to-lane mapping and default sizing for the tile-scroller engine.
package tile_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        MISS = 2'd2,
        OVER = 2'd3
    } game_state_t;

    // Physical key to lane mapping used by the keyboard front end
    localparam int unsigned LANE_D     = 0;
    localparam int unsigned LANE_F     = 1;
    localparam int unsigned LANE_SPACE = 2;
    localparam int unsigned LANE_J     = 3;
    localparam int unsigned LANE_K     = 4;

    localparam int unsigned DEF_NUM_LANES      = 5;
    localparam int unsigned DEF_NUM_ROWS       = 4;
    localparam int unsigned DEF_ROW_H          = 120;
    localparam int unsigned DEF_START_SPEED    = 1;
    localparam int unsigned DEF_SPEED_STEP     = 2;
    localparam int unsigned DEF_MAX_SPEED      = 12;
    localparam int unsigned DEF_ROWS_PER_LEVEL = 5;
    localparam int unsigned DEF_LIVES          = 3;
    localparam int unsigned DEF_MISS_FRAMES    = 30;
    localparam int unsigned DEF_BONUS          = 5;
    localparam int unsigned DEF_SCORE_W        = 10;

endpackage

// File: rtl/tile_row_stack.sv
// Visible row stack: per row a one-hot lane, bonus flag and hit flag, plus the incoming row
// and its pending bonus bit. Row NUM_ROWS-1 is the judge row; shifting moves rows downward.
module tile_row_stack #(
    parameter int unsigned NUM_LANES = 5,
    parameter int unsigned NUM_ROWS  = 4
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          init,
    input  logic [NUM_LANES-1:0]          initLane,
    input  logic                          shift,
    input  logic [NUM_LANES-1:0]          newLane,
    input  logic                          newBonus,
    input  logic                          markHit,
    output logic [NUM_ROWS*NUM_LANES-1:0] laneRows,
    output logic [NUM_ROWS-1:0]           bonusRows,
    output logic [NUM_ROWS-1:0]           hitRows,
    output logic [NUM_LANES-1:0]          incoming
);

    localparam int unsigned STACK_W = NUM_ROWS * NUM_LANES;

    logic pendBonus;
    logic anyBonus_c;
    logic newPend_c;

    // Staircase start pattern: row r sits in lane (NUM_ROWS-1-r) mod NUM_LANES
    function automatic logic [STACK_W-1:0] defaultRows();
        logic [STACK_W-1:0] rows;
        rows = '0;
        for (int r = 0; r < int'(NUM_ROWS); r++) begin
            rows[r*int'(NUM_LANES) + (int'(NUM_ROWS) - 1 - r) % int'(NUM_LANES)] = 1'b1;
        end
        return rows;
    endfunction

    // Bonus flags that remain on screen after a shift: rows 0..NUM_ROWS-2 plus the pending row
    always_comb begin
        anyBonus_c = pendBonus;
        for (int r = 0; r < int'(NUM_ROWS) - 1; r++) begin
            anyBonus_c = anyBonus_c | bonusRows[r];
        end
    end

    assign newPend_c = newBonus & ~anyBonus_c;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            laneRows  <= defaultRows();
            bonusRows <= '0;
            hitRows   <= '0;
            incoming  <= NUM_LANES'(1);
            pendBonus <= 1'b0;
        end else if (init) begin
            laneRows  <= defaultRows();
            bonusRows <= '0;
            hitRows   <= '0;
            incoming  <= initLane;
            pendBonus <= 1'b0;
        end else if (shift) begin
            laneRows  <= {laneRows[STACK_W-NUM_LANES-1:0], incoming};
            bonusRows <= {bonusRows[NUM_ROWS-2:0], pendBonus};
            hitRows   <= {hitRows[NUM_ROWS-2:0], 1'b0};
            incoming  <= newLane;
            pendBonus <= newPend_c;
        end else if (markHit) begin
            hitRows[NUM_ROWS-1] <= 1'b1;
        end
    end

endmodule

// File: rtl/tile_lane_engine.sv
// Tile-scroller game-state engine: judging, scrolling, speed levels, score, lives and game FSM,
// advanced by a one-cycle frame_tick strobe in the Clk domain.
module tile_lane_engine
    import tile_pkg::*;
#(
    parameter int unsigned NUM_LANES      = DEF_NUM_LANES,
    parameter int unsigned NUM_ROWS       = DEF_NUM_ROWS,
    parameter int unsigned ROW_H          = DEF_ROW_H,
    parameter int unsigned START_SPEED    = DEF_START_SPEED,
    parameter int unsigned SPEED_STEP     = DEF_SPEED_STEP,
    parameter int unsigned MAX_SPEED      = DEF_MAX_SPEED,
    parameter int unsigned ROWS_PER_LEVEL = DEF_ROWS_PER_LEVEL,
    parameter int unsigned LIVES          = DEF_LIVES,
    parameter int unsigned MISS_FRAMES    = DEF_MISS_FRAMES,
    parameter int unsigned BONUS          = DEF_BONUS,
    parameter int unsigned SCORE_W        = DEF_SCORE_W
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            frame_tick,
    input  logic                            key_valid,
    input  logic [$clog2(NUM_LANES)-1:0]    key_lane,
    input  logic [7:0]                      rand_lane,
    input  logic                            rand_bonus,
    output logic [NUM_ROWS*NUM_LANES-1:0]   tile_rows,
    output logic [NUM_ROWS-1:0]             bonus_rows,
    output logic [NUM_ROWS-1:0]             hit_rows,
    output logic [NUM_LANES-1:0]            incoming,
    output logic [$clog2(ROW_H)-1:0]        scroll_off,
    output logic [3:0]                      speed,
    output logic [SCORE_W-1:0]              score,
    output logic [$clog2(LIVES+1)-1:0]      lives,
    output logic [1:0]                      state,
    output logic                            hit_pulse,
    output logic                            miss_pulse
);

    localparam int unsigned OFF_W     = $clog2(ROW_H);
    localparam int unsigned LIV_W     = $clog2(LIVES + 1);
    localparam int unsigned MT_W      = $clog2(MISS_FRAMES + 1);
    localparam int unsigned LVL_W     = $clog2(ROWS_PER_LEVEL + 1);
    localparam int unsigned SCORE_MAX = (1 << SCORE_W) - 1;

    game_state_t            gameState;
    logic [MT_W-1:0]        missTimer;
    logic [LVL_W-1:0]       levelCnt;

    logic [NUM_LANES-1:0]   judgeLane_c;
    logic [NUM_LANES-1:0]   keyOneHot_c;
    logic [NUM_LANES-1:0]   spawnLane_c;
    logic                   judgeHit_c;
    logic                   keyMatch_c;
    logic                   canJudge_c;
    logic                   hitNow_c;
    logic                   keyMiss_c;
    logic                   shift_c;
    logic                   escape_c;
    logic                   miss_c;
    logic                   markHit_c;
    logic                   init_c;
    logic [31:0]            sum_c;
    logic                   rowEnd_c;
    logic [31:0]            hitSum_c;
    logic [SCORE_W-1:0]     scoreHit_c;
    logic [SCORE_W-1:0]     scoreMiss_c;
    logic [31:0]            speedUp_c;
    logic [3:0]             speedNext_c;
    logic                   levelWrap_c;

    assign state = gameState;

    // Key judging against the pre-shift judge row
    assign judgeLane_c = tile_rows[(NUM_ROWS-1)*NUM_LANES +: NUM_LANES];
    assign judgeHit_c  = hit_rows[NUM_ROWS-1];
    assign keyOneHot_c = NUM_LANES'(1) << key_lane;
    assign keyMatch_c  = |(keyOneHot_c & judgeLane_c);
    assign canJudge_c  = key_valid & ~judgeHit_c;
    assign hitNow_c    = canJudge_c & keyMatch_c & ((gameState == IDLE) | (gameState == PLAY));
    assign keyMiss_c   = canJudge_c & ~keyMatch_c & (gameState == PLAY);

    // Scroll and shift; a row judged this cycle (hit or miss) cannot also escape
    assign sum_c    = 32'(scroll_off) + 32'(speed);
    assign rowEnd_c = (sum_c >= ROW_H);
    assign shift_c  = (gameState == PLAY) & frame_tick & rowEnd_c;
    assign escape_c = shift_c & ~judgeHit_c & ~hitNow_c & ~keyMiss_c;
    assign miss_c   = keyMiss_c | escape_c;
    assign markHit_c = hitNow_c | keyMiss_c;
    assign init_c   = (gameState == OVER) & key_valid;

    assign spawnLane_c = NUM_LANES'(1) << (32'(rand_lane) % NUM_LANES);

    // Saturating score arithmetic
    assign hitSum_c    = 32'(score) + 32'd1 + (bonus_rows[NUM_ROWS-1] ? 32'(BONUS) : 32'd0);
    assign scoreHit_c  = (hitSum_c > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(hitSum_c);
    assign scoreMiss_c = (score == '0) ? '0 : score - SCORE_W'(1);

    assign speedUp_c   = 32'(speed) + 32'(SPEED_STEP);
    assign speedNext_c = (speedUp_c > MAX_SPEED) ? 4'(MAX_SPEED) : 4'(speedUp_c);
    assign levelWrap_c = (32'(levelCnt) + 32'd1 >= ROWS_PER_LEVEL);

    tile_row_stack #(
        .NUM_LANES (NUM_LANES),
        .NUM_ROWS  (NUM_ROWS)
    ) u_rowStack (
        .Clk       (Clk),
        .Reset     (Reset),
        .init      (init_c),
        .initLane  (spawnLane_c),
        .shift     (shift_c),
        .newLane   (spawnLane_c),
        .newBonus  (rand_bonus),
        .markHit   (markHit_c),
        .laneRows  (tile_rows),
        .bonusRows (bonus_rows),
        .hitRows   (hit_rows),
        .incoming  (incoming)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            gameState  <= IDLE;
            scroll_off <= '0;
            speed      <= 4'(START_SPEED);
            score      <= '0;
            lives      <= LIV_W'(LIVES);
            levelCnt   <= '0;
            missTimer  <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            hit_pulse  <= hitNow_c;
            miss_pulse <= miss_c;
            unique case (gameState)
                IDLE: begin
                    if (hitNow_c) begin
                        score     <= scoreHit_c;
                        gameState <= PLAY;
                    end
                end
                PLAY: begin
                    if (hitNow_c) begin
                        score <= scoreHit_c;
                    end
                    if (frame_tick) begin
                        if (rowEnd_c) begin
                            scroll_off <= OFF_W'(sum_c - ROW_H);
                            if (levelWrap_c) begin
                                levelCnt <= '0;
                                speed    <= speedNext_c;
                            end else begin
                                levelCnt <= levelCnt + LVL_W'(1);
                            end
                        end else begin
                            scroll_off <= OFF_W'(sum_c);
                        end
                    end
                    if (miss_c) begin
                        score <= scoreMiss_c;
                        lives <= lives - LIV_W'(1);
                        if (lives <= LIV_W'(1)) begin
                            gameState <= OVER;
                        end else begin
                            gameState <= MISS;
                            missTimer <= MT_W'(MISS_FRAMES);
                        end
                    end
                end
                MISS: begin
                    // Frozen; only the freeze timer runs
                    if (frame_tick) begin
                        if (missTimer <= MT_W'(1)) begin
                            missTimer <= '0;
                            gameState <= PLAY;
                        end else begin
                            missTimer <= missTimer - MT_W'(1);
                        end
                    end
                end
                OVER: begin
                    if (key_valid) begin
                        gameState  <= IDLE;
                        scroll_off <= '0;
                        speed      <= 4'(START_SPEED);
                        score      <= '0;
                        lives      <= LIV_W'(LIVES);
                        levelCnt   <= '0;
                        missTimer  <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_lane_engine.sv
// Directed bench for tile_lane_engine with a rule-level game model checked every cycle.
module tb_tile_lane_engine;

    localparam int NL  = 5;
    localparam int NR  = 4;
    localparam int RH  = 120;
    localparam int SP0 = 1;
    localparam int STP = 2;
    localparam int SMX = 12;
    localparam int RPL = 5;
    localparam int LV  = 3;
    localparam int MF  = 30;
    localparam int BON = 5;
    localparam int SMAX = 1023;
    localparam int GUARD = 40000;

    logic        Clk;
    logic        Reset;
    logic        frame_tick;
    logic        key_valid;
    logic [2:0]  key_lane;
    logic [7:0]  rand_lane;
    logic        rand_bonus;
    logic [19:0] tile_rows;
    logic [3:0]  bonus_rows;
    logic [3:0]  hit_rows;
    logic [4:0]  incoming;
    logic [6:0]  scroll_off;
    logic [3:0]  speed;
    logic [9:0]  score;
    logic [1:0]  lives;
    logic [1:0]  state;
    logic        hit_pulse;
    logic        miss_pulse;

    tile_lane_engine dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .key_valid  (key_valid),
        .key_lane   (key_lane),
        .rand_lane  (rand_lane),
        .rand_bonus (rand_bonus),
        .tile_rows  (tile_rows),
        .bonus_rows (bonus_rows),
        .hit_rows   (hit_rows),
        .incoming   (incoming),
        .scroll_off (scroll_off),
        .speed      (speed),
        .score      (score),
        .lives      (lives),
        .state      (state),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int nTests = 0;
    int nFail  = 0;
    bit chkEn  = 1'b0;

    // Game model: lanes per row, flags, and scalar game variables (0=IDLE 1=PLAY 2=MISS 3=OVER)
    int mLane[NR];
    bit mBon[NR];
    bit mHit[NR];
    int mInc, mOff, mSpeed, mScore, mLives, mState, mTimer, mLevel, mShifts;
    bit mPend, mHitP, mMissP;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void modelReset(input int incLane);
        for (int r = 0; r < NR; r++) begin
            mLane[r] = (NR - 1 - r) % NL;
            mBon[r]  = 1'b0;
            mHit[r]  = 1'b0;
        end
        mInc = incLane; mPend = 1'b0;
        mOff = 0; mSpeed = SP0; mScore = 0; mLives = LV;
        mState = 0; mTimer = 0; mLevel = 0; mShifts = 0;
        mHitP = 1'b0; mMissP = 1'b0;
    endfunction

    function automatic void award();
        mScore = mScore + 1 + (mBon[NR-1] ? BON : 0);
        if (mScore > SMAX) mScore = SMAX;
    endfunction

    function automatic void modelStep(input bit kv, input int kl, input bit ft, input int rl, input bit rb);
        bit missed;
        bit anyB;
        int s;
        missed = 1'b0;
        mHitP = 1'b0;
        mMissP = 1'b0;
        case (mState)
            0: if (kv && !mHit[NR-1] && kl == mLane[NR-1]) begin
                award(); mHit[NR-1] = 1'b1; mHitP = 1'b1; mState = 1;
            end
            1: begin
                if (kv && !mHit[NR-1]) begin
                    if (kl == mLane[NR-1]) begin award(); mHitP = 1'b1; end
                    else missed = 1'b1;
                    mHit[NR-1] = 1'b1;
                end
                if (ft) begin
                    s = mOff + mSpeed;
                    if (s >= RH) begin
                        mOff = s - RH;
                        if (!mHit[NR-1]) missed = 1'b1;
                        for (int r = NR - 1; r > 0; r--) begin
                            mLane[r] = mLane[r-1]; mBon[r] = mBon[r-1]; mHit[r] = mHit[r-1];
                        end
                        mLane[0] = mInc; mBon[0] = mPend; mHit[0] = 1'b0;
                        mInc = rl % NL;
                        anyB = 1'b0;
                        for (int r = 0; r < NR; r++) anyB |= mBon[r];
                        mPend = rb && !anyB;
                        mShifts++;
                        mLevel++;
                        if (mLevel == RPL) begin
                            mLevel = 0;
                            mSpeed = (mSpeed + STP > SMX) ? SMX : mSpeed + STP;
                        end
                    end else begin
                        mOff = s;
                    end
                end
                if (missed) begin
                    mMissP = 1'b1;
                    mLives--;
                    if (mScore > 0) mScore--;
                    if (mLives == 0) mState = 3;
                    else begin mState = 2; mTimer = MF; end
                end
            end
            2: if (ft) begin
                mTimer--;
                if (mTimer == 0) mState = 1;
            end
            default: if (kv) modelReset(rl % NL);
        endcase
    endfunction

    task automatic compareAll();
        logic [19:0] expT;
        logic [3:0]  expB, expH;
        expT = '0; expB = '0; expH = '0;
        for (int r = 0; r < NR; r++) begin
            expT[r*NL + mLane[r]] = 1'b1;
            expB[r] = mBon[r];
            expH[r] = mHit[r];
        end
        chk("tile_rows",  32'(tile_rows),  32'(expT));
        chk("bonus_rows", 32'(bonus_rows), 32'(expB));
        chk("hit_rows",   32'(hit_rows),   32'(expH));
        chk("incoming",   32'(incoming),   32'(1) << mInc);
        chk("scroll_off", 32'(scroll_off), 32'(mOff));
        chk("speed",      32'(speed),      32'(mSpeed));
        chk("score",      32'(score),      32'(mScore));
        chk("lives",      32'(lives),      32'(mLives));
        chk("state",      32'(state),      32'(mState));
        chk("hit_pulse",  32'(hit_pulse),  32'(mHitP));
        chk("miss_pulse", 32'(miss_pulse), 32'(mMissP));
    endtask

    always @(posedge Clk) begin
        #1;
        if (chkEn) compareAll();
    end

    // One clock: drive on the falling edge, advance the model at the rising edge, release strobes
    task automatic step(input bit kv, input int kl, input bit ft, input int rl, input bit rb);
        @(negedge Clk);
        key_valid = kv; key_lane = 3'(kl); frame_tick = ft; rand_lane = 8'(rl); rand_bonus = rb;
        @(posedge Clk);
        modelStep(kv, kl, ft, rl, rb);
        #1;
        key_valid = 1'b0; frame_tick = 1'b0; rand_bonus = 1'b0;
    endtask

    task automatic ticks(input int n, input int rl);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1, rl, 1'b0);
    endtask

    // Perfect player: hits every judge row, frame_tick every cycle, bonuses always requested
    task automatic autoRun(input int shiftGoal, input int scoreGoal);
        int guard;
        guard = 0;
        while ((mShifts < shiftGoal || mScore < scoreGoal) && guard < GUARD) begin
            step((mState <= 1) && !mHit[NR-1], mLane[NR-1], 1'b1, int'($urandom_range(0, 255)), 1'b1);
            guard++;
        end
        if (guard >= GUARD) begin
            nTests++; nFail++;
            $display("FAIL autorun_timeout: shifts %0d score %0d after %0d cycles", mShifts, mScore, guard);
        end
    endtask

    int speedAt[7] = '{3, 5, 7, 9, 11, 12, 12};

    initial begin
        Reset = 1'b0; frame_tick = 1'b0; key_valid = 1'b0; key_lane = '0;
        rand_lane = '0; rand_bonus = 1'b0;
        modelReset(0);
        #23;
        chk("rst_tile_rows", 32'(tile_rows), 32'h08888);
        chk("rst_incoming",  32'(incoming), 32'h1);
        chk("rst_speed",     32'(speed), 32'd1);
        chk("rst_lives",     32'(lives), 32'd3);
        chk("rst_state",     32'(state), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        chkEn = 1'b1;

        // IDLE: wrong key and frame_tick ignored, judge lane 0 starts the game
        step(1'b1, 1, 1'b1, 0, 1'b0);
        chk("idle_wrong_state", 32'(state), 32'd0);
        chk("idle_no_scroll",   32'(scroll_off), 32'd0);
        step(1'b1, 0, 1'b0, 0, 1'b0);
        chk("start_state", 32'(state), 32'd1);
        chk("start_score", 32'(score), 32'd1);
        chk("start_pulse", 32'(hit_pulse), 32'd1);
        ticks(119, 2);
        chk("scroll_119", 32'(scroll_off), 32'd119);
        ticks(1, 2);
        chk("shift_scroll", 32'(scroll_off), 32'd0);
        chk("shift_rows",   32'(tile_rows), 32'h11101);
        chk("shift_inc",    32'(incoming), 32'h04);
        chk("shift_hits",   32'(hit_rows), 32'd0);

        // Wrong key in PLAY (judge lane 1): miss, freeze, keys ignored, resume after 30 ticks
        step(1'b1, 0, 1'b0, 0, 1'b0);
        chk("miss_pulse_key", 32'(miss_pulse), 32'd1);
        chk("miss_lives",     32'(lives), 32'd2);
        chk("miss_score",     32'(score), 32'd0);
        chk("miss_state",     32'(state), 32'd2);
        step(1'b1, 1, 1'b0, 0, 1'b0);
        chk("miss_key_ignored", 32'(hit_pulse), 32'd0);
        ticks(29, 0);
        chk("miss_hold", 32'(state), 32'd2);
        ticks(1, 0);
        chk("miss_resume", 32'(state), 32'd1);

        // Escapes: first shift is safe (missed row marked), then two escapes end the game
        ticks(120, 4);
        chk("safe_shift_lives", 32'(lives), 32'd2);
        ticks(120, 4);
        chk("escape_pulse", 32'(miss_pulse), 32'd1);
        chk("escape_lives", 32'(lives), 32'd1);
        chk("escape_score_floor", 32'(score), 32'd0);
        ticks(30, 0);
        ticks(120, 1);
        chk("over_state", 32'(state), 32'd3);
        chk("over_lives", 32'(lives), 32'd0);
        ticks(3, 0);

        // Restart from OVER: incoming from rand_lane 7 -> lane 2
        step(1'b1, 3, 1'b0, 7, 1'b0);
        chk("restart_state", 32'(state), 32'd0);
        chk("restart_rows",  32'(tile_rows), 32'h08888);
        chk("restart_inc",   32'(incoming), 32'h04);
        chk("restart_lives", 32'(lives), 32'd3);

        // Same-cycle correct key and row-ending frame_tick
        step(1'b1, 0, 1'b0, 0, 1'b0);
        ticks(120, 0);
        ticks(119, 0);
        chk("pre_same_scroll", 32'(scroll_off), 32'd119);
        step(1'b1, 1, 1'b1, 0, 1'b0);
        chk("same_hit",   32'(hit_pulse), 32'd1);
        chk("same_nomiss", 32'(miss_pulse), 32'd0);
        chk("same_score", 32'(score), 32'd2);
        chk("same_scroll", 32'(scroll_off), 32'd0);

        // Asynchronous reset mid-game, checked before any clock edge
        @(negedge Clk);
        #2;
        chkEn = 1'b0;
        Reset = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_score", 32'(score), 32'd0);
        chk("async_rows",  32'(tile_rows), 32'h08888);
        modelReset(0);
        @(negedge Clk);
        Reset = 1'b1;
        chkEn = 1'b1;

        // Speed ramp every five shifts, capped at 12
        for (int k = 0; k < 7; k++) begin
            autoRun(5 * (k + 1), 0);
            chk("speed_level", 32'(speed), 32'(speedAt[k]));
        end

        // Score saturates at 1023 with bonus hits
        autoRun(0, SMAX);
        autoRun(mShifts + 12, 0);
        chk("score_sat", 32'(score), 32'd1023);

        @(negedge Clk);
        chkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
